automata_stream_ctrl: RTL and testbench

Sequences one NFA automaton instance (e.g. the 4-report ltl3c0lw cluster) over a byte stream. Issues the automaton reset/start-of-data sequence, gates `run` per accepted symbol and tags each non-zero report vector with its symbol offset. Buffers the tagged reports in an internal FIFO for a downstream collector. Sits between the engine's symbol feeder and the report aggregation logic.

---
 rtl/automata_stream_ctrl.sv | 139 +++++++++++++
 tb/tb_automata_stream_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/automata_stream_ctrl.sv
// Sequences one NFA automaton over a byte stream: reset/start-of-data, run gating,
// offset tagging of non-zero report vectors and a first-word-fall-through report FIFO.
module automata_stream_ctrl #(
  parameter int N_REPORT   = 4,
  parameter int OFFSET_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  input  logic                         in_last,
  output logic                         auto_reset,
  output logic                         auto_run,
  output logic [7:0]                   auto_symbols,
  input  logic [N_REPORT-1:0]          auto_report,
  output logic                         rpt_valid,
  input  logic                         rpt_ready,
  output logic [OFFSET_W+N_REPORT-1:0] rpt_data,
  output logic [OFFSET_W-1:0]          symbol_count,
  output logic                         offset_wrap
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam int REC_W = OFFSET_W + N_REPORT;

  typedef enum logic [2:0] {IDLE, ARST, STREAM, DRAIN, FLUSH} state_t;

  state_t              state_reg, state_next;
  logic [RC_W-1:0]     rst_cnt_reg;
  logic                run_q, sample_q;
  logic [7:0]          symbols_reg;
  logic [OFFSET_W-1:0] count_reg, offset_q, sample_off_q;
  logic                wrap_reg;
  logic [REC_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    fill_reg, pending;
  logic                accept, push, pop, fifo_empty;

  assign fifo_empty   = (fill_reg == '0);
  assign rpt_valid    = !fifo_empty;
  assign rpt_data     = fifo_mem[rd_ptr_reg];
  assign pop          = rpt_valid && rpt_ready;
  assign push         = sample_q && (auto_report != '0);
  assign accept       = in_valid && in_ready;
  assign auto_run     = run_q;
  assign auto_symbols = symbols_reg;
  assign symbol_count = count_reg;
  assign offset_wrap  = wrap_reg;

  // Reports still in the automaton pipeline are counted against free space, so
  // one FIFO slot always stays free for the in-flight sample.
  assign pending = fill_reg + CNT_W'(run_q) + CNT_W'(sample_q);

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    auto_reset = 1'b0;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        busy       = 1'b0;
        auto_reset = 1'b1;
        if (start) state_next = ARST;
      end
      ARST: begin
        auto_reset = 1'b1;
        if (rst_cnt_reg == RC_W'(RST_CYCLES - 1)) state_next = STREAM;
      end
      STREAM: begin
        in_ready = (pending <= CNT_W'(FIFO_DEPTH - 2));
        if (in_valid && in_ready && in_last) state_next = DRAIN;
      end
      DRAIN: begin
        // Last sample is the one with no run pulse behind it.
        if (sample_q && !run_q) state_next = FLUSH;
      end
      FLUSH: begin
        if (fifo_empty) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      rst_cnt_reg  <= '0;
      run_q        <= 1'b0;
      sample_q     <= 1'b0;
      symbols_reg  <= '0;
      count_reg    <= '0;
      offset_q     <= '0;
      sample_off_q <= '0;
      wrap_reg     <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      rst_cnt_reg <= (state_reg == ARST) ? rst_cnt_reg + RC_W'(1) : '0;
      run_q       <= accept;
      sample_q    <= run_q;
      if (run_q) sample_off_q <= offset_q;
      if (state_reg == IDLE && start) begin
        count_reg <= '0;
        wrap_reg  <= 1'b0;
      end else if (accept) begin
        symbols_reg <= in_data;
        offset_q    <= count_reg;
        count_reg   <= count_reg + OFFSET_W'(1);
        if (&count_reg) wrap_reg <= 1'b1;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   fill_reg <= fill_reg + CNT_W'(1);
        2'b01:   fill_reg <= fill_reg - CNT_W'(1);
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {sample_off_q, auto_report};
  end

endmodule

// File: tb/tb_automata_stream_ctrl.sv
// Directed bench for automata_stream_ctrl; a behavioural automaton reports the
// upper nibble of each run symbol one cycle after the run pulse.
module tb_automata_stream_ctrl;
  localparam int NR = 4;
  localparam int OW = 4;

  logic clk = 0;
  logic reset = 1, start = 0, in_valid = 0, in_last = 0, rpt_ready = 1;
  logic [7:0] in_data = 0;
  logic busy, done, in_ready, auto_reset, auto_run, rpt_valid, offset_wrap;
  logic [7:0] auto_symbols;
  logic [NR-1:0] auto_report, rep_reg;
  logic [OW+NR-1:0] rpt_data;
  logic [OW-1:0] symbol_count;
  logic [OW+NR-1:0] got[$];
  int checks = 0, errors = 0;

  automata_stream_ctrl #(.N_REPORT(NR), .OFFSET_W(OW), .FIFO_DEPTH(8), .RST_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .auto_reset(auto_reset), .auto_run(auto_run), .auto_symbols(auto_symbols),
    .auto_report(auto_report), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_data(rpt_data), .symbol_count(symbol_count), .offset_wrap(offset_wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rep_reg <= auto_run ? auto_symbols[7:4] : '0;
  assign auto_report = rep_reg;

  always @(negedge clk) if (rpt_valid && rpt_ready) got.push_back(rpt_data);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1; in_data = d; in_last = l;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("send_ready", {31'd0, in_ready}, 1);
    tick();
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_done(input string tag);
    int dn = 0, bad = 0;
    for (int n = 0; n < 60; n++) begin
      if (done) dn++;
      if (done && rpt_valid) bad++;
      if (!busy) break;
      tick();
    end
    chk({tag, "_idle"}, {31'd0, busy}, 0);
    chk({tag, "_done_cnt"}, dn, 1);
    chk({tag, "_done_early"}, bad, 0);
  endtask

  task automatic begin_job();
    start = 1; tick(); start = 0;
    tick(); tick();
  endtask

  initial begin
    int acc, dn;
    tick(); tick();
    reset = 0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_auto_reset", {31'd0, auto_reset}, 1);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_rpt_valid", {31'd0, rpt_valid}, 0);
    chk("rst_auto_run", {31'd0, auto_run}, 0);
    chk("rst_count", symbol_count, 0);
    chk("rst_wrap", {31'd0, offset_wrap}, 0);
    chk("rst_done", {31'd0, done}, 0);
    $display("reset state checked");

    // 1/2: ARST timing and report tagging
    start = 1; tick(); start = 0;
    chk("arst1_busy", {31'd0, busy}, 1);
    chk("arst1_auto_reset", {31'd0, auto_reset}, 1);
    tick();
    chk("arst2_auto_reset", {31'd0, auto_reset}, 1);
    chk("arst2_in_ready", {31'd0, in_ready}, 0);
    tick();
    chk("stream_auto_reset", {31'd0, auto_reset}, 0);
    chk("stream_in_ready", {31'd0, in_ready}, 1);
    send(8'h05, 0);
    chk("sym1_auto_run", {31'd0, auto_run}, 1);
    chk("sym1_auto_symbols", auto_symbols, 8'h05);
    send(8'h07, 0);
    send(8'h10, 1);
    wait_done("job1");
    chk("job1_records", got.size(), 1);
    chk("job1_rec0", got[0], {4'd2, 4'b0001});
    chk("job1_count", symbol_count, 3);
    $display("job1: %0d records, count %0d", got.size(), symbol_count);

    // 3: backpressure
    got.delete();
    rpt_ready = 0;
    begin_job();
    in_valid = 1; in_data = 8'hF0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      acc += int'(in_ready);
      tick();
    end
    in_valid = 0;
    chk("bp_accepts", acc, 7);
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    chk("bp_rpt_valid", {31'd0, rpt_valid}, 1);
    start = 1; tick(); start = 0;
    chk("bp_start_ignored", symbol_count, 7);
    chk("bp_start_busy", {31'd0, busy}, 1);
    rpt_ready = 1;
    for (int n = 0; n < 30; n++) begin
      if (!rpt_valid) break;
      tick();
    end
    chk("bp_records", got.size(), 7);
    for (int i = 0; i < 7; i++) chk($sformatf("bp_rec%0d", i), got[i], {i[3:0], 4'hF});
    send(8'h00, 1);
    wait_done("job2");
    chk("job2_count", symbol_count, 8);
    $display("job2: accepts %0d, records %0d", acc, got.size());

    // 4: input stalls
    got.delete();
    begin_job();
    in_valid = 1; in_data = 8'h30; tick();
    chk("stall_run0", {31'd0, auto_run}, 1);
    in_valid = 0; tick();
    chk("stall_run1", {31'd0, auto_run}, 0);
    tick();
    chk("stall_run2", {31'd0, auto_run}, 0);
    in_valid = 1; in_data = 8'h40; in_last = 1; tick();
    chk("stall_run3", {31'd0, auto_run}, 1);
    in_valid = 0; in_last = 0;
    wait_done("job3");
    chk("stall_records", got.size(), 2);
    chk("stall_rec0", got[0], {4'd0, 4'h3});
    chk("stall_rec1", got[1], {4'd1, 4'h4});
    $display("job3: records %0d", got.size());

    // 5: wrap and done after FIFO empties
    got.delete();
    rpt_ready = 0;
    begin_job();
    for (int i = 0; i < 18; i++) send((i == 17) ? 8'h20 : 8'h00, (i == 17));
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dn++;
      tick();
    end
    chk("wrap_hold_done", dn, 0);
    chk("wrap_hold_busy", {31'd0, busy}, 1);
    chk("wrap_hold_valid", {31'd0, rpt_valid}, 1);
    rpt_ready = 1;
    wait_done("job4");
    chk("wrap_records", got.size(), 1);
    chk("wrap_rec0", got[0], {4'd1, 4'h2});
    chk("wrap_count", symbol_count, 2);
    chk("wrap_flag", {31'd0, offset_wrap}, 1);
    $display("job4: count %0d wrap %0d", symbol_count, offset_wrap);

    // 6: mid-job reset
    got.delete();
    rpt_ready = 0;
    start = 1; tick(); start = 0;
    chk("restart_wrap_clr", {31'd0, offset_wrap}, 0);
    chk("restart_count_clr", symbol_count, 0);
    tick(); tick();
    for (int i = 0; i < 3; i++) send(8'h10, 0);
    tick(); tick(); tick();
    chk("mid_rpt_valid_pre", {31'd0, rpt_valid}, 1);
    in_valid = 1; in_data = 8'h10;
    reset = 1; tick();
    in_valid = 0; reset = 0;
    chk("mid_rpt_valid", {31'd0, rpt_valid}, 0);
    chk("mid_in_ready", {31'd0, in_ready}, 0);
    chk("mid_auto_reset", {31'd0, auto_reset}, 1);
    chk("mid_busy", {31'd0, busy}, 0);
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dn++;
      tick();
    end
    chk("mid_no_done", dn, 0);
    chk("mid_no_records", got.size(), 0);
    $display("mid-job reset: rpt_valid %0d busy %0d", rpt_valid, busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
